// File: rtl/iter_multiplier.sv
// -----------------------------------------------------------------------------
// iter_multiplier
//   Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH bits. An accepted
//   Start launches WIDTH add/shift steps. The product then appears on
//   Product_Hi/Product_Lo together with a one-cycle Done pulse. Done drives the
//   Enable of the downstream product registers, so it must never pulse twice
//   for one operation.
//
//   Optional feature macro: MUL_SIGNED_EN
//     defined   : Signed=1 treats operands as two's complement. Magnitudes are
//                 multiplied and the result is negated when the signs differ.
//     undefined : Signed is ignored, and no sign/negation logic is built.
//
// Ports
//   Clk         in   rising-edge clock
//   Reset_n     in   asynchronous active-low reset
//   Start       in   operation request, sampled only in IDLE
//   Signed      in   two's-complement mode (only with MUL_SIGNED_EN)
//   Op_A        in   multiplicand, captured when Start is accepted
//   Op_B        in   multiplier, captured when Start is accepted
//   Busy        out  high during RUN and DONE
//   Done        out  one-cycle pulse, product valid in the same cycle
//   Product_Lo  out  product bits [WIDTH-1:0]
//   Product_Hi  out  product bits [2*WIDTH-1:WIDTH]
// -----------------------------------------------------------------------------
module iter_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Op_A,
  input  logic [WIDTH-1:0] Op_B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Product_Lo,
  output logic [WIDTH-1:0] Product_Hi
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  // acc_q: upper half is the running partial sum, lower half starts as the
  // multiplier and is consumed one bit per step as the sum shifts in.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     a_mag_s;
  logic [WIDTH-1:0]     b_mag_s;
  logic [WIDTH:0]       add_s;
  logic [WIDTH:0]       sum_s;
  logic [2*WIDTH-1:0]   step_s;
  logic [2*WIDTH-1:0]   final_s;

`ifdef MUL_SIGNED_EN
  logic                 neg_q, neg_d;
  logic                 neg_in_s;

  // Two's-complement magnitude. The most negative value maps to 2^(WIDTH-1),
  // which still fits as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v[WIDTH-1]) begin
      r = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Operand conditioning at acceptance: magnitudes plus the result sign.
  always_comb begin
    a_mag_s  = Op_A;
    b_mag_s  = Op_B;
    neg_in_s = 1'b0;
    if (Signed) begin
      a_mag_s  = magnitude(Op_A);
      b_mag_s  = magnitude(Op_B);
      neg_in_s = Op_A[WIDTH-1] ^ Op_B[WIDTH-1];
    end else begin
      a_mag_s  = Op_A;
      b_mag_s  = Op_B;
      neg_in_s = 1'b0;
    end
  end

  // Final product, negated modulo 2^(2*WIDTH) when the operand signs differed.
  always_comb begin
    final_s = step_s;
    if (neg_q) begin
      final_s = (~step_s) + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      final_s = step_s;
    end
  end
`else
  logic                 unused_signed_s;

  assign unused_signed_s = Signed;

  // Unsigned-only build: operands pass straight through.
  always_comb begin
    a_mag_s = Op_A;
    b_mag_s = Op_B;
    final_s = step_s;
  end
`endif

  // One add/shift step: conditional (WIDTH+1)-bit add into the upper half,
  // keeping the carry, then shift the whole accumulator right by one.
  always_comb begin
    if (acc_q[0]) begin
      add_s = {1'b0, mcand_q};
    end else begin
      add_s = {(WIDTH+1){1'b0}};
    end
    sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + add_s;
    step_s = {sum_s, acc_q[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. RUN leaves on the step where the counter reads 1,
  // so RUN lasts exactly WIDTH cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: operand capture on acceptance, one step per RUN
  // cycle. The product register is loaded on the edge that enters DONE.
  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
`ifdef MUL_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          acc_d   = {{WIDTH{1'b0}}, b_mag_s};
          mcand_d = a_mag_s;
          cnt_d   = CW'(WIDTH);
`ifdef MUL_SIGNED_EN
          neg_d   = neg_in_s;
`endif
        end else begin
          acc_d   = acc_q;
          mcand_d = mcand_q;
          cnt_d   = cnt_q;
        end
      end
      ST_RUN: begin
        acc_d = step_s;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          prod_d = final_s;
        end else begin
          prod_d = prod_q;
        end
      end
      ST_DONE: begin
        acc_d = acc_q;
        cnt_d = cnt_q;
      end
      default: begin
        acc_d = acc_q;
        cnt_d = cnt_q;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      acc_q   <= {(2*WIDTH){1'b0}};
      mcand_q <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      prod_q  <= {(2*WIDTH){1'b0}};
`ifdef MUL_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
`ifdef MUL_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  // Output decode from the upcoming state, so Busy/Done come out of flops.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      ST_IDLE: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
      ST_RUN: begin
        busy_d = 1'b1;
        done_d = 1'b0;
      end
      ST_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // Status output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Product_Lo = prod_q[WIDTH-1:0];
  assign Product_Hi = prod_q[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_iter_multiplier.sv
// -----------------------------------------------------------------------------
// tb_iter_multiplier
//   Directed and random stimulus for iter_multiplier. Expected products come
//   from plain integer multiplication. Inputs change and outputs are sampled
//   on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_iter_multiplier;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic        Signed = 1'b0;
  logic [15:0] Op_A = 16'h0000;
  logic [15:0] Op_B = 16'h0000;
  logic        Busy;
  logic        Done;
  logic [15:0] Product_Lo;
  logic [15:0] Product_Hi;

  int checks = 0;
  int errors = 0;

  iter_multiplier #(.WIDTH(16)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .Signed     (Signed),
    .Op_A       (Op_A),
    .Op_B       (Op_B),
    .Busy       (Busy),
    .Done       (Done),
    .Product_Lo (Product_Lo),
    .Product_Hi (Product_Hi)
  );

  always #5 Clk = ~Clk;

  // Reference product: 32-bit result of plain integer multiplication.
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
    logic eff;
    int   sa;
    int   sb;
`ifdef MUL_SIGNED_EN
    eff = s;
`else
    eff = s & 1'b0;
`endif
    if (eff) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end else begin
      sa = int'({16'd0, a});
      sb = int'({16'd0, b});
    end
    return 32'(sa * sb);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One operation from IDLE. With disturb set, Start is pulsed with new
  // operands at cycle +5 and during the DONE cycle.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [31:0] exp, input bit disturb);
    int done_at;
    int extra;
    @(negedge Clk);
    Op_A = a; Op_B = b; Signed = s; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    check({tag, "_busy"}, {31'd0, Busy}, 32'd1);
    done_at = 0;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      if (k > 1) @(negedge Clk);
      if (Done) begin
        done_at = k;
      end else if (disturb && k == 5) begin
        Start = 1'b1; Op_A = 16'd7; Op_B = 16'd7; Signed = 1'b0;
      end else if (disturb && k == 6) begin
        Start = 1'b0;
      end
    end
    check({tag, "_latency"}, 32'(done_at), 32'd17);
    check({tag, "_prod"}, {Product_Hi, Product_Lo}, exp);
    if (disturb) begin
      Start = 1'b1; Op_A = 16'd7; Op_B = 16'd7;
    end
    @(negedge Clk);
    Start = 1'b0;
    check({tag, "_done_pulse"}, {31'd0, Done}, 32'd0);
    check({tag, "_busy_end"}, {31'd0, Busy}, 32'd0);
    if (disturb) begin
      extra = 0;
      repeat (25) begin
        @(negedge Clk);
        if (Done) extra++;
      end
      check({tag, "_extra_done"}, 32'(extra), 32'd0);
      check({tag, "_hold"}, {Product_Hi, Product_Lo}, exp);
    end
  endtask

  initial begin
    int seen;
    int nd;
    int prev;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;

    // Reset state, during and after reset.
    repeat (3) @(negedge Clk);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_prod", {Product_Hi, Product_Lo}, 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);
    check("post_rst_busy", {31'd0, Busy}, 32'd0);
    check("post_rst_prod", {Product_Hi, Product_Lo}, 32'd0);

    // Basic and boundary unsigned products.
    run_op("mul_3x5", 16'd3, 16'd5, 1'b0, 32'h0000_000F, 1'b0);
    run_op("mul_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 1'b0);
    run_op("mul_zero", 16'h0000, 16'h1234, 1'b0, 32'h0000_0000, 1'b0);

    // Start and operand changes while busy are ignored.
    run_op("ignore_busy", 16'd2, 16'd3, 1'b0, 32'h0000_0006, 1'b1);

    // Reset in the middle of RUN aborts with no Done.
    @(negedge Clk);
    Op_A = 16'h1234; Op_B = 16'h5678; Signed = 1'b0; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (7) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_done", {31'd0, Done}, 32'd0);
    check("abort_prod", {Product_Hi, Product_Lo}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge Clk);
      if (Done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    run_op("after_abort", 16'h1234, 16'h5678, 1'b0, ref_mul(16'h1234, 16'h5678, 1'b0), 1'b0);

    // Start held high: one product every 18 cycles.
    @(negedge Clk);
    Op_A = 16'h0100; Op_B = 16'h0100; Signed = 1'b0; Start = 1'b1;
    nd = 0;
    prev = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge Clk);
      if (Done) begin
        nd++;
        check("b2b_prod", {Product_Hi, Product_Lo}, 32'h0001_0000);
        if (nd == 1) check("b2b_first", 32'(c), 32'd17);
        else check("b2b_period", 32'(c - prev), 32'd18);
        prev = c;
      end
    end
    check("b2b_count", 32'(nd), 32'd3);
    Start = 1'b0;
    for (int c = 0; c < 40 && Busy; c++) @(negedge Clk);
    check("b2b_idle", {31'd0, Busy}, 32'd0);

    // Signed mode (unsigned results when the feature is not built).
    run_op("sgn_m1xm1", 16'hFFFF, 16'hFFFF, 1'b1, ref_mul(16'hFFFF, 16'hFFFF, 1'b1), 1'b0);
    run_op("sgn_minx1", 16'h8000, 16'h0001, 1'b1, ref_mul(16'h8000, 16'h0001, 1'b1), 1'b0);
    run_op("sgn_minxmin", 16'h8000, 16'h8000, 1'b1, ref_mul(16'h8000, 16'h8000, 1'b1), 1'b0);

    // Random operands and modes.
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(1, 0));
      run_op("rand", ra, rb, rs, ref_mul(ra, rb, rs), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound on the whole run.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
